// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch front end: widths, constants and the
// fetch FSM state encoding.
package cpu_defs;

    localparam int ADDR_W       = 32;
    localparam int INSTR_W      = 32;
    localparam int PC_INCREMENT = 4;
    localparam int NOP_INSTR    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DROP  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats freeze, freeze beats load; with no
// load the stage fills with a bubble so decode never sees a stale instruction.
module if_id_reg
    import cpu_defs::*;
#(
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int INSTR_WIDTH = INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   flush,
    input  logic                   freeze,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   valid,
    output logic [ADDR_WIDTH-1:0]  stage_pc,
    output logic [INSTR_WIDTH-1:0] stage_instr,
    output logic                   stage_valid
);

    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            stage_pc    <= '0;
            stage_instr <= NOP;
            stage_valid <= 1'b0;
        end else if (!freeze) begin
            if (load) begin
                stage_pc    <= pc;
                stage_instr <= valid ? instr : NOP;
                stage_valid <= valid;
            end else begin
                stage_pc    <= '0;
                stage_instr <= NOP;
                stage_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, req/ready handshake to instruction
// memory, a one-entry skid buffer for responses that arrive while frozen.
module fetch_stage
    import cpu_defs::*;
#(
    parameter int                    ADDR_WIDTH  = ADDR_W,
    parameter int                    INSTR_WIDTH = INSTR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_address,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0]  if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic                   if_id_valid
);

    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INCREMENT);

    fetch_state_t state, next_state;

    logic [ADDR_WIDTH-1:0]  addr_inc;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [ADDR_WIDTH-1:0]  skid_pc;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic                   skid_valid;

    logic                   req_nxt;
    logic [ADDR_WIDTH-1:0]  addr_nxt;
    logic [ADDR_WIDTH-1:0]  redirect_nxt;
    logic                   skid_load;
    logic                   skid_clear;
    logic                   ifid_load;
    logic [ADDR_WIDTH-1:0]  ifid_pc;
    logic [INSTR_WIDTH-1:0] ifid_instr;
    logic                   ifid_valid;

    assign addr_inc = imem_addr + INC;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A branch that arrives while a request is still waiting cannot move
    // imem_addr, so DROP swallows the stale response before redirecting.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = FETCH;
            FETCH: begin
                if (branch_taken) begin
                    next_state = imem_ready ? FETCH : DROP;
                end else if (imem_ready && freeze) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (branch_taken || !freeze) begin
                    next_state = FETCH;
                end
            end
            DROP: begin
                if (!branch_taken && imem_ready) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        redirect_nxt = redirect_pc;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        ifid_load    = 1'b0;
        ifid_pc      = addr_inc;
        ifid_instr   = imem_rdata;
        ifid_valid   = 1'b1;
        case (state)
            IDLE: begin
                req_nxt = 1'b1;
                if (branch_taken) begin
                    addr_nxt = branch_address;
                end
            end
            FETCH: begin
                ifid_load = imem_ready;
                if (branch_taken) begin
                    if (imem_ready) begin
                        addr_nxt = branch_address;
                    end else begin
                        redirect_nxt = branch_address;
                    end
                end else if (imem_ready) begin
                    addr_nxt = addr_inc;
                    if (freeze) begin
                        skid_load = 1'b1;
                        req_nxt   = 1'b0;
                    end
                end
            end
            HOLD: begin
                ifid_load  = 1'b1;
                ifid_pc    = skid_pc;
                ifid_instr = skid_instr;
                ifid_valid = skid_valid;
                if (branch_taken) begin
                    addr_nxt   = branch_address;
                    req_nxt    = 1'b1;
                    skid_clear = 1'b1;
                end else if (!freeze) begin
                    req_nxt    = 1'b1;
                    skid_clear = 1'b1;
                end
            end
            DROP: begin
                if (branch_taken) begin
                    redirect_nxt = branch_address;
                end else if (imem_ready) begin
                    addr_nxt = redirect_pc;
                end
            end
            default: begin
                req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            redirect_pc <= RESET_PC;
            skid_pc     <= '0;
            skid_instr  <= '0;
            skid_valid  <= 1'b0;
        end else begin
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            redirect_pc <= redirect_nxt;
            if (skid_load) begin
                skid_pc    <= addr_inc;
                skid_instr <= imem_rdata;
                skid_valid <= 1'b1;
            end else if (skid_clear) begin
                skid_valid <= 1'b0;
            end
        end
    end

    if_id_reg #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .flush       (branch_taken),
        .freeze      (freeze),
        .pc          (ifid_pc),
        .instr       (ifid_instr),
        .valid       (ifid_valid),
        .stage_pc    (if_id_pc),
        .stage_instr (if_id_instr),
        .stage_valid (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of reset/streaming vectors,
// a scoreboard of fetched instructions, and directed freeze/branch/reset cases.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        sb_item;
    bit          sb_en = 1'b0;
    logic [31:0] next_fetch;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = '0;
    logic        prev_rst = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    fetch_stage #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic rdy, input logic frz, input logic br, input logic [31:0] tgt);
        imem_ready     = rdy;
        freeze         = frz;
        branch_taken   = br;
        branch_address = tgt;
        step();
    endtask

    task automatic reset_dut();
        sb_en          = 1'b0;
        rst            = 1'b0;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = '0;
        imem_ready     = 1'b0;
        repeat (3) step();
        sb_q.delete();
        next_fetch = 32'h0;
        rst = 1'b1;
    endtask

    // Scoreboard plus the "address stable while waiting" invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb_en) begin
            if (if_id_valid && (!prev_valid || if_id_pc != prev_pc)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL sb_unexpected: got pc %h, expected no delivery", if_id_pc);
                end else begin
                    sb_item = sb_q.pop_front();
                    check_output("sb_pc", if_id_pc, sb_item.pc);
                    check_output("sb_instr", if_id_instr, sb_item.instr);
                end
            end
            if (imem_req && imem_ready) begin
                check_output("fetch_seq", imem_addr, next_fetch);
                next_fetch = imem_addr + 32'd4;
                sb_q.push_back({imem_addr + 32'd4, mem_word(imem_addr)});
            end
        end
        if (prev_rst === 1'b1 && prev_wait === 1'b1) begin
            check_output("req_stable", {31'b0, imem_req}, 32'd1);
            check_output("addr_stable", imem_addr, prev_addr);
        end
        prev_valid = if_id_valid;
        prev_pc    = if_id_pc;
        prev_rst   = rst;
        prev_wait  = imem_req && !imem_ready;
        prev_addr  = imem_addr;
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h4};
        vecs[2] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h8};
        vecs[3] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'hC};

        // Reset state, then zero-wait streaming from the table
        reset_dut();
        check_output("rst_req", {31'b0, imem_req}, 32'd0);
        check_output("rst_addr", imem_addr, 32'h0);
        check_output("rst_valid", {31'b0, if_id_valid}, 32'd0);
        check_output("rst_pc", if_id_pc, 32'h0);
        check_output("rst_instr", if_id_instr, 32'h0);
        sb_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i].ready, 1'b0, 1'b0, 32'h0);
            check_output("t1_req", {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
            check_output("t1_addr", imem_addr, vecs[i].exp_addr);
            check_output("t1_valid", {31'b0, if_id_valid}, {31'b0, vecs[i].exp_valid});
            check_output("t1_pc", if_id_pc, vecs[i].exp_pc);
            check_output("t1_instr", if_id_instr, vecs[i].exp_valid ? mem_word(vecs[i].exp_pc - 32'd4) : 32'h0);
        end

        // Memory ready every third cycle: bubbles between, no address skipped
        reset_dut();
        sb_en = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            apply_stimulus((cyc % 3) == 2, 1'b0, 1'b0, 32'h0);
            if ((cyc % 3) == 2) begin
                check_output("t2_valid", {31'b0, if_id_valid}, 32'd1);
            end else begin
                check_output("t2_bubble_valid", {31'b0, if_id_valid}, 32'd0);
                check_output("t2_bubble_instr", if_id_instr, 32'h0);
            end
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check_output("t2_sb_drained", sb_q.size(), 32'd0);
        check_output("t2_next_addr", imem_addr, 32'd24);

        // Freeze on the ready cycle at 0x10, held four cycles
        reset_dut();
        sb_en = 1'b1;
        repeat (5) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t3_addr_pre", imem_addr, 32'h10);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
            check_output("t3_hold_req", {31'b0, imem_req}, 32'd0);
            check_output("t3_hold_addr", imem_addr, 32'h14);
            check_output("t3_hold_pc", if_id_pc, 32'h10);
            check_output("t3_hold_valid", {31'b0, if_id_valid}, 32'd1);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t3_rel_pc", if_id_pc, 32'h14);
        check_output("t3_rel_instr", if_id_instr, mem_word(32'h10));
        check_output("t3_rel_req", {31'b0, imem_req}, 32'd1);
        check_output("t3_rel_addr", imem_addr, 32'h14);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t3_next_pc", if_id_pc, 32'h18);

        // Branch while a request at 0x20 is waiting
        reset_dut();
        repeat (9) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t4_addr_pre", imem_addr, 32'h20);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h200);
        check_output("t4_br_valid", {31'b0, if_id_valid}, 32'd0);
        check_output("t4_br_addr", imem_addr, 32'h20);
        check_output("t4_br_req", {31'b0, imem_req}, 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check_output("t4_drop_addr", imem_addr, 32'h20);
        check_output("t4_drop_valid", {31'b0, if_id_valid}, 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t4_redir_addr", imem_addr, 32'h200);
        check_output("t4_discard_valid", {31'b0, if_id_valid}, 32'd0);
        check_output("t4_discard_instr", if_id_instr, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t4_tgt_pc", if_id_pc, 32'h204);
        check_output("t4_tgt_valid", {31'b0, if_id_valid}, 32'd1);
        check_output("t4_tgt_instr", if_id_instr, mem_word(32'h200));
        check_output("t4_tgt_addr", imem_addr, 32'h204);

        // Branch together with freeze while in HOLD
        reset_dut();
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check_output("t5_hold_req", {31'b0, imem_req}, 32'd0);
        check_output("t5_hold_addr", imem_addr, 32'hC);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h300);
        check_output("t5_flush_valid", {31'b0, if_id_valid}, 32'd0);
        check_output("t5_flush_instr", if_id_instr, 32'h0);
        check_output("t5_br_addr", imem_addr, 32'h300);
        check_output("t5_br_req", {31'b0, imem_req}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t5_tgt_pc", if_id_pc, 32'h304);
        check_output("t5_tgt_instr", if_id_instr, mem_word(32'h300));

        // Reset in the middle of a waiting request, then PC wrap
        reset_dut();
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check_output("t6_wait_req", {31'b0, imem_req}, 32'd1);
        check_output("t6_wait_addr", imem_addr, 32'h8);
        rst = 1'b0;
        step();
        check_output("t6_rst_req", {31'b0, imem_req}, 32'd0);
        check_output("t6_rst_addr", imem_addr, 32'h0);
        check_output("t6_rst_valid", {31'b0, if_id_valid}, 32'd0);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        check_output("t6_br_addr", imem_addr, 32'hFFFF_FFF8);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t6_pre_wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        check_output("t6_pre_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t6_wrap_addr", imem_addr, 32'h0);
        check_output("t6_wrap_pc", if_id_pc, 32'h0);
        check_output("t6_wrap_valid", {31'b0, if_id_valid}, 32'd1);
        check_output("t6_wrap_instr", if_id_instr, mem_word(32'hFFFF_FFFC));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
